// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver and key decoder: frame FSM state codes,
// set-2 prefix/key codes and the frame parity helper.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_UP  = 8'h75;

    // PS/2 uses odd parity across the data byte and the parity bit together.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 line receiver: synchronizes and filters the keyboard lines, deframes
// 11-bit frames and aborts a frame that stalls mid-way.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT);
    localparam logic [FCW-1:0] F_LAST  = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

    logic           clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic           clk_filt_r, clk_prev_r;
    logic [FCW-1:0] flt_cnt_r;
    logic           fall_s;
    logic [1:0]     state_r;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic           par_r;
    logic [TCW-1:0] to_cnt_r;
    logic [7:0]     rx_byte_r;
    logic           rx_valid_r, rx_err_r;

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            {clk_meta_r, clk_sync_r, data_meta_r, data_sync_r} <= 4'b1111;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock deglitcher: the filtered level follows only a run of FILTER_LEN differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_r <= 1'b1;
            clk_prev_r <= 1'b1;
            flt_cnt_r  <= '0;
        end else begin
            clk_prev_r <= clk_filt_r;
            if (clk_sync_r == clk_filt_r) begin
                flt_cnt_r <= '0;
            end else if (flt_cnt_r == F_LAST) begin
                clk_filt_r <= clk_sync_r;
                flt_cnt_r  <= '0;
            end else begin
                flt_cnt_r <= flt_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fall_s = clk_prev_r & ~clk_filt_r;

    // Frame FSM with mid-frame stall timeout; a fall in the same cycle beats the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            to_cnt_r   <= '0;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (!data_sync_r) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r <= {data_sync_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_r   <= data_sync_r;
                        state_r <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_sync_r && odd_parity_ok(shift_r, par_r)) begin
                            rx_valid_r <= 1'b1;
                            rx_byte_r  <= shift_r;
                        end else begin
                            rx_err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (to_cnt_r == TO_LAST) begin
                    rx_err_r <= 1'b1;
                    state_r  <= ST_IDLE;
                    to_cnt_r <= '0;
                end else begin
                    to_cnt_r <= to_cnt_r + {{(TCW-1){1'b0}}, 1'b1};
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    assign rx_byte  = rx_byte_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;

endmodule

// File: rtl/ps2_flap_ctrl.sv
// PS/2 keyboard front end for the game: receives scan codes and turns the flap
// and restart keys into a held flap level plus one-cycle flap/restart pulses.
module ps2_flap_ctrl
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT     = 50000,
    parameter logic [7:0] KEY_FLAP    = 8'h29,
    parameter logic [7:0] KEY_RESTART = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       flap_level,
    output logic       flap_pulse,
    output logic       restart_pulse
);

    logic ext_r, brk_r;
    logic flap_level_r, flap_pulse_r, restart_pulse_r;
    logic is_flap_s, is_restart_s;

    ps2_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign is_flap_s    = ((rx_byte == KEY_FLAP) && !ext_r) || ((rx_byte == CODE_UP) && ext_r);
    assign is_restart_s = (rx_byte == KEY_RESTART) && !ext_r && !brk_r;

    // Scan-code decoder: prefixes arm flags, any other code acts and clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_r           <= 1'b0;
            brk_r           <= 1'b0;
            flap_level_r    <= 1'b0;
            flap_pulse_r    <= 1'b0;
            restart_pulse_r <= 1'b0;
        end else begin
            flap_pulse_r    <= 1'b0;
            restart_pulse_r <= 1'b0;
            if (rx_err) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end else if (rx_valid) begin
                case (rx_byte)
                    CODE_EXT: ext_r <= 1'b1;
                    CODE_BRK: brk_r <= 1'b1;
                    default: begin
                        ext_r <= 1'b0;
                        brk_r <= 1'b0;
                        if (is_flap_s) begin
                            if (brk_r) begin
                                flap_level_r <= 1'b0;
                            end else begin
                                flap_pulse_r <= ~flap_level_r;
                                flap_level_r <= 1'b1;
                            end
                        end
                        restart_pulse_r <= is_restart_s;
                    end
                endcase
            end
        end
    end

    assign flap_level    = flap_level_r;
    assign flap_pulse    = flap_pulse_r;
    assign restart_pulse = restart_pulse_r;

endmodule
